// File: rtl/seq_scheduler.sv
// Frame-level run controller for the audio sequencer: starts one program run per
// sample frame, watches done/error/timeout, drains, and gates host coefficient writes.
module seq_scheduler #(
    parameter int FRAME_W   = 4,
    parameter int CODE_W    = 8,
    parameter int TIMEOUT_W = 10
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sample_stb,
    output logic                 seq_run,
    output logic [FRAME_W-1:0]   frame,
    input  logic                 seq_done,
    input  logic                 seq_error,
    input  logic                 host_req,
    input  logic [CODE_W-1:0]    host_addr,
    input  logic [31:0]          host_data,
    output logic                 host_ack,
    output logic                 coef_we,
    output logic [CODE_W-1:0]    coef_waddr,
    output logic [31:0]          coef_wdata,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_sticky,
    output logic                 timeout_sticky,
    output logic [7:0]           overrun_count,
    output logic [TIMEOUT_W-1:0] last_cycles
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [TIMEOUT_W-1:0] RUN_MAX = {TIMEOUT_W{1'b1}};

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_ctr_q, frame_ctr_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [TIMEOUT_W-1:0] run_cnt_q, run_cnt_d;
    logic [TIMEOUT_W-1:0] last_q, last_d;
    logic                 drain_cnt_q, drain_cnt_d;
    logic                 seq_run_q, seq_run_d;
    logic                 host_ack_q, host_ack_d;
    logic                 coef_we_q, coef_we_d;
    logic [CODE_W-1:0]    coef_waddr_q, coef_waddr_d;
    logic [31:0]          coef_wdata_q, coef_wdata_d;
    logic                 busy_q;
    logic                 frame_done_q, frame_done_d;
    logic                 err_q, err_d;
    logic                 tmo_q, tmo_d;
    logic [7:0]           ovr_q, ovr_d;

    logic start, run_exit, drain_last;

    assign start      = (state_q == S_IDLE) && sample_stb && enable;
    assign run_exit   = (state_q == S_RUN) && (seq_done || seq_error || (run_cnt_q == RUN_MAX));
    assign drain_last = (state_q == S_DRAIN) && drain_cnt_q;

    // All state moves on the falling edge; the sequencer samples on the rising edge.
    always_ff @(negedge ck) begin
        if (rst) begin
            state_q      <= S_IDLE;
            frame_ctr_q  <= '0;
            frame_q      <= '0;
            run_cnt_q    <= '0;
            last_q       <= '0;
            drain_cnt_q  <= 1'b0;
            seq_run_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            coef_we_q    <= 1'b0;
            coef_waddr_q <= '0;
            coef_wdata_q <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= 1'b0;
            ovr_q        <= '0;
        end else begin
            state_q      <= state_d;
            frame_ctr_q  <= frame_ctr_d;
            frame_q      <= frame_d;
            run_cnt_q    <= run_cnt_d;
            last_q       <= last_d;
            drain_cnt_q  <= drain_cnt_d;
            seq_run_q    <= seq_run_d;
            host_ack_q   <= host_ack_d;
            coef_we_q    <= coef_we_d;
            coef_waddr_q <= coef_waddr_d;
            coef_wdata_q <= coef_wdata_d;
            busy_q       <= (state_d != S_IDLE);
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
            ovr_q        <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)      state_d = S_RUN;
            S_RUN:   if (run_exit)   state_d = S_DRAIN;
            S_DRAIN: if (drain_last) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_ctr_d  = frame_ctr_q + FRAME_W'(sample_stb);
        frame_d      = frame_q;
        run_cnt_d    = run_cnt_q;
        last_d       = last_q;
        drain_cnt_d  = drain_cnt_q;
        seq_run_d    = seq_run_q;
        host_ack_d   = 1'b0;
        coef_we_d    = 1'b0;
        coef_waddr_d = coef_waddr_q;
        coef_wdata_d = coef_wdata_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        tmo_d        = tmo_q;
        ovr_d        = ovr_q;
        case (state_q)
            S_IDLE: begin
                // A frame start beats a pending host write; the host simply waits.
                if (start) begin
                    frame_d   = frame_ctr_q;
                    run_cnt_d = '0;
                    seq_run_d = 1'b1;
                end else if (host_req && !host_ack_q) begin
                    coef_we_d    = 1'b1;
                    host_ack_d   = 1'b1;
                    coef_waddr_d = host_addr;
                    coef_wdata_d = host_data;
                end
            end
            S_RUN: begin
                if (run_exit) begin
                    seq_run_d   = 1'b0;
                    last_d      = run_cnt_q;
                    drain_cnt_d = 1'b0;
                    if (seq_error) err_d = 1'b1;
                    if (!seq_done && !seq_error) tmo_d = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_last) frame_done_d = 1'b1;
            end
            default: ;
        endcase
        if ((state_q != S_IDLE) && sample_stb && (ovr_q != 8'hFF))
            ovr_d = ovr_q + 8'd1;
    end

    assign seq_run        = seq_run_q;
    assign frame          = frame_q;
    assign host_ack       = host_ack_q;
    assign coef_we        = coef_we_q;
    assign coef_waddr     = coef_waddr_q;
    assign coef_wdata     = coef_wdata_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign err_sticky     = err_q;
    assign timeout_sticky = tmo_q;
    assign overrun_count  = ovr_q;
    assign last_cycles    = last_q;

endmodule
